// File: rtl/sequence_engine_if.sv
// Bundle between the game control FSM / board I/O and sequence_engine.
// The master side drives start/clear/inputs; the engine (slave) drives prompts and status.
interface sequence_engine_if #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16
);
    localparam int LW = $clog2(DEPTH + 1);

    logic                start;
    logic                clear;
    logic [CHANNELS-1:0] inputs;
    logic [CHANNELS-1:0] prompt;
    logic                busy;
    logic [LW-1:0]       level;
    logic                full;
    logic                pass;
    logic                fail;

    modport master (
        output start, clear, inputs,
        input  prompt, busy, level, full, pass, fail
    );

    modport slave (
        input  start, clear, inputs,
        output prompt, busy, level, full, pass, fail
    );
endinterface

// File: rtl/sequence_engine.sv
// Memory-game engine: grows an LFSR-derived symbol sequence, plays it as timed prompts, checks the replies.
// Optional listen timeout is compiled in when SEQ_TIMEOUT_EN is defined.
module sequence_engine #(
    parameter int          CHANNELS      = 4,
    parameter int          DEPTH         = 16,
    parameter int          TICK_DIV      = 25000000,
    parameter logic [15:0] SEED          = 16'hACE1
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_TICKS = 10
`endif
) (
    input logic              clock,
    input logic              reset,
    sequence_engine_if.slave seqIf
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_APPEND   = 3'd1;
    localparam logic [2:0] S_PLAY_ON  = 3'd2;
    localparam logic [2:0] S_PLAY_OFF = 3'd3;
    localparam logic [2:0] S_LISTEN   = 3'd4;
    localparam logic [2:0] S_PASS     = 3'd5;
    localparam logic [2:0] S_FAIL     = 3'd6;

    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0]       LEVEL_MAX = LW'(DEPTH);
    localparam logic [CHANNELS-1:0] ONE       = CHANNELS'(1);

    logic [2:0]          state_q, state_d;
    logic [LW-1:0]       level_q, level_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CHANNELS-1:0] prev_q;
    logic [TW-1:0]       tick_q, tick_d;
    logic [SW-1:0]       mem_q [DEPTH];

    logic                memWe;
    logic                full;
    logic                tickDone;
    logic                lfsrFb;
    logic [SW-1:0]       sym;
    logic [SW-1:0]       memAtIdx;
    logic [CHANNELS-1:0] expectOnehot;
    logic [CHANNELS-1:0] rise;
    logic [LW-1:0]       idxInc;

`ifdef SEQ_TIMEOUT_EN
    localparam int            PW         = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(TIMEOUT_TICKS - 1);
    logic [PW-1:0]            phase_q, phase_d;
`endif

    assign full         = (level_q == LEVEL_MAX);
    assign tickDone     = (tick_q == TICK_LAST);
    assign lfsrFb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign sym          = SW'(lfsr_q % 16'(CHANNELS));
    assign memAtIdx     = mem_q[idx_q[AW-1:0]];
    assign expectOnehot = ONE << memAtIdx;
    assign rise         = seqIf.inputs & ~prev_q;
    assign idxInc       = idx_q + LW'(1);

    // Next-state logic; clear overrides whatever the current state decided.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        tick_d  = tickDone ? '0 : tick_q + TW'(1);
        memWe   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        phase_d = tickDone ? phase_q + PW'(1) : phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (seqIf.start) begin
                    if (full) begin
                        state_d = S_PLAY_ON;
                        idx_d   = '0;
                        tick_d  = '0;
                    end else begin
                        state_d = S_APPEND;
                    end
                end
            end
            S_APPEND: begin
                memWe   = 1'b1;
                level_d = level_q + LW'(1);
                lfsr_d  = {lfsrFb, lfsr_q[15:1]};
                idx_d   = '0;
                tick_d  = '0;
                state_d = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (tickDone) begin
                    tick_d  = '0;
                    state_d = S_PLAY_OFF;
                end
            end
            S_PLAY_OFF: begin
                if (tickDone) begin
                    tick_d = '0;
                    if (idxInc < level_q) begin
                        idx_d   = idxInc;
                        state_d = S_PLAY_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = S_LISTEN;
`ifdef SEQ_TIMEOUT_EN
                        phase_d = '0;
`endif
                    end
                end
            end
            // A single rising edge on the expected channel advances; anything else that rises fails.
            S_LISTEN: begin
                if (rise != '0) begin
                    if (rise == expectOnehot) begin
                        idx_d  = idxInc;
                        tick_d = '0;
`ifdef SEQ_TIMEOUT_EN
                        phase_d = '0;
`endif
                        if (idxInc == level_q) begin
                            state_d = S_PASS;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tickDone && (phase_q == PHASE_LAST)) begin
                    state_d = S_FAIL;
                end
`endif
            end
            S_PASS:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (seqIf.clear) begin
            state_d = S_IDLE;
            level_d = '0;
            idx_d   = '0;
            memWe   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            lfsr_q  <= SEED;
            prev_q  <= '0;
            tick_q  <= '0;
`ifdef SEQ_TIMEOUT_EN
            phase_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            prev_q  <= seqIf.inputs;
            tick_q  <= tick_d;
`ifdef SEQ_TIMEOUT_EN
            phase_q <= phase_d;
`endif
        end
    end

    // Symbol storage has no reset; entries above level are never read.
    always_ff @(posedge clock) begin
        if (memWe) begin
            mem_q[level_q[AW-1:0]] <= sym;
        end
    end

    assign seqIf.prompt = (state_q == S_PLAY_ON) ? expectOnehot : '0;
    assign seqIf.busy   = (state_q != S_IDLE);
    assign seqIf.level  = level_q;
    assign seqIf.full   = full;
    assign seqIf.pass   = (state_q == S_PASS);
    assign seqIf.fail   = (state_q == S_FAIL);
endmodule

// File: tb/tb_sequence_engine.sv
// Directed bench for sequence_engine: table of game rounds plus hand-written clear/hold/listen-wait cases.
// With SEQ_TIMEOUT_EN defined the listen-wait case expects the 40-cycle timeout instead.
module tb_sequence_engine;
    localparam int CH = 4;
    localparam int DP = 4;
    localparam int TD = 4;

    typedef struct {
        int         wrongAt;
        logic [3:0] wrongMask;
        bit         holdFirst;
        logic [3:0] expFirstPrompt;
        int         expLevel;
        bit         expFull;
    } roundVec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] mLfsr;
    int          mLevel;
    logic [1:0]  mMem [DP];
    roundVec_t   vecs [8];

    sequence_engine_if #(.CHANNELS(CH), .DEPTH(DP)) seqIf ();

    sequence_engine #(
        .CHANNELS(CH),
        .DEPTH(DP),
        .TICK_DIV(TD),
        .SEED(16'hACE1)
`ifdef SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_TICKS(10)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .seqIf(seqIf)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference sequence: symbol is the LFSR value mod 4 before it advances.
    task automatic modelAppend();
        logic fb;
        mMem[mLevel] = mLfsr[1:0];
        fb = mLfsr[0] ^ mLfsr[2] ^ mLfsr[3] ^ mLfsr[5];
        mLfsr = {fb, mLfsr[15:1]};
        mLevel++;
    endtask

    // Pulses start and walks every prompt phase; returns in the last PLAY_OFF cycle.
    task automatic runPrompts(input logic [3:0] expFirst, output int n);
        bit replay;
        replay = (mLevel == DP);
        if (!replay) modelAppend();
        n = mLevel;
        @(negedge clock);
        seqIf.start = 1'b1;
        @(negedge clock);
        seqIf.start = 1'b0;
        checkOutput("busyAfterStart", seqIf.busy, 1);
        if (!replay) begin
            checkOutput("appendPromptLow", seqIf.prompt, 0);
            checkOutput("appendLevelOld", seqIf.level, mLevel - 1);
            @(negedge clock);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 0) checkOutput("firstPrompt", seqIf.prompt, expFirst);
            else checkOutput("promptOnHead", seqIf.prompt, onehot(mMem[i]));
            repeat (TD - 1) @(negedge clock);
            checkOutput("promptOnTail", seqIf.prompt, onehot(mMem[i]));
            @(negedge clock);
            checkOutput("promptOffHead", seqIf.prompt, 0);
            repeat (TD - 1) @(negedge clock);
        end
    endtask

    task automatic listenPresses(input int wrongAt, input logic [3:0] wrongMask, input int n);
        logic [3:0] m;
        bit         wrong;
        bit         last;
        checkOutput("listenBusy", seqIf.busy, 1);
        checkOutput("listenPromptLow", seqIf.prompt, 0);
        for (int j = 0; j < n; j++) begin
            wrong = (j == wrongAt);
            last  = (j == n - 1);
            m = wrong ? wrongMask : onehot(mMem[j]);
            seqIf.inputs = m;
            @(negedge clock);
            seqIf.inputs = '0;
            checkOutput("failPulse", seqIf.fail, wrong);
            checkOutput("passPulse", seqIf.pass, !wrong && last);
            @(negedge clock);
            if (wrong || last) begin
                checkOutput("busyAfterResult", seqIf.busy, 0);
                checkOutput("pulseOneCycle", {seqIf.pass, seqIf.fail}, 0);
                break;
            end
        end
    endtask

    task automatic applyStimulus(input roundVec_t v);
        int n;
        runPrompts(v.expFirstPrompt, n);
        if (v.holdFirst) seqIf.inputs = onehot(mMem[0]);
        @(negedge clock);
        if (v.holdFirst) begin
            repeat (3) begin
                checkOutput("heldNoPulse", {seqIf.pass, seqIf.fail}, 0);
                checkOutput("heldBusy", seqIf.busy, 1);
                @(negedge clock);
            end
            seqIf.inputs = '0;
            @(negedge clock);
        end
        listenPresses(v.wrongAt, v.wrongMask, n);
        checkOutput("roundLevel", seqIf.level, v.expLevel);
        checkOutput("roundFull", seqIf.full, v.expFull);
    endtask

    initial begin
        int n;
        // Symbols from SEED 16'hACE1 are 1,0,0,0, so every round opens with prompt 4'b0010.
        vecs[0] = '{-1, 4'b0000, 1'b0, 4'b0010, 1, 1'b0};
        vecs[1] = '{-1, 4'b0000, 1'b0, 4'b0010, 2, 1'b0};
        vecs[2] = '{-1, 4'b0000, 1'b1, 4'b0010, 3, 1'b0};
        vecs[3] = '{-1, 4'b0000, 1'b0, 4'b0010, 4, 1'b1};
        vecs[4] = '{ 0, 4'b0100, 1'b0, 4'b0010, 4, 1'b1};
        vecs[5] = '{ 3, 4'b1000, 1'b0, 4'b0010, 4, 1'b1};
        vecs[6] = '{ 1, 4'b1010, 1'b0, 4'b0010, 4, 1'b1};
        vecs[7] = '{-1, 4'b0000, 1'b0, 4'b0010, 4, 1'b1};

        seqIf.start  = 1'b0;
        seqIf.clear  = 1'b0;
        seqIf.inputs = '0;
        reset  = 1'b0;
        mLfsr  = 16'hACE1;
        mLevel = 0;
        repeat (3) @(negedge clock);
        checkOutput("resetPrompt", seqIf.prompt, 0);
        checkOutput("resetLevel", seqIf.level, 0);
        checkOutput("resetBusy", seqIf.busy, 0);
        checkOutput("resetFull", seqIf.full, 0);
        checkOutput("resetPassFail", {seqIf.pass, seqIf.fail}, 0);
        reset = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k]);
        end

        // Full sequence, no input in LISTEN.
        runPrompts(4'b0010, n);
        @(negedge clock);
`ifdef SEQ_TIMEOUT_EN
        repeat (39) @(negedge clock);
        checkOutput("noEarlyTimeout", seqIf.fail, 0);
        @(negedge clock);
        checkOutput("timeoutFail", seqIf.fail, 1);
        @(negedge clock);
        checkOutput("idleAfterTimeout", seqIf.busy, 0);
        checkOutput("levelAfterTimeout", seqIf.level, 4);
`else
        repeat (60) @(negedge clock);
        checkOutput("listenWaits", {seqIf.pass, seqIf.fail, seqIf.busy}, 3'b001);
        listenPresses(-1, 4'b0000, n);
`endif

        // Clear during PLAY_ON of a replay.
        @(negedge clock);
        seqIf.start = 1'b1;
        @(negedge clock);
        seqIf.start = 1'b0;
        @(negedge clock);
        checkOutput("promptBeforeClear", seqIf.prompt, 4'b0010);
        seqIf.clear = 1'b1;
        @(negedge clock);
        seqIf.clear = 1'b0;
        mLevel = 0;
        checkOutput("clearPrompt", seqIf.prompt, 0);
        checkOutput("clearBusy", seqIf.busy, 0);
        checkOutput("clearLevel", seqIf.level, 0);
        checkOutput("clearFull", seqIf.full, 0);
        checkOutput("clearNoPulse", {seqIf.pass, seqIf.fail}, 0);
        @(negedge clock);
        checkOutput("clearNoLatePulse", {seqIf.pass, seqIf.fail, seqIf.busy}, 0);

        // LFSR keeps running across clear: after four appends it holds 16'h2ACE, symbol 2.
        applyStimulus('{-1, 4'b0000, 1'b0, 4'b0100, 1, 1'b0});

        // start and clear together: clear wins.
        @(negedge clock);
        seqIf.start = 1'b1;
        seqIf.clear = 1'b1;
        @(negedge clock);
        seqIf.start = 1'b0;
        seqIf.clear = 1'b0;
        checkOutput("startClearBusy", seqIf.busy, 0);
        checkOutput("startClearLevel", seqIf.level, 0);
        @(negedge clock);
        checkOutput("startClearStillIdle", seqIf.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
